// File: rtl/turn_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | turn_scheduler: runs whole game turns, granting the board_update_v port to the     |
// | human move path or the AI engine.                            Revision: 1.0 initial |
// +----------------------------------------------------------------------------------+
module turn_scheduler #(
   parameter int          AI_ENABLE  = 1,
   parameter logic        AI_PLAYER  = 1'b1,
   parameter logic [23:0] AI_TIMEOUT = 24'd5000000
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       hum_req,
   input  logic [3:0] hum_pid,
   input  logic [5:0] hum_move,
   output logic       hum_ack,
   output logic       hum_rej,
   output logic       ai_start,
   input  logic       ai_done,
   input  logic [3:0] ai_pid,
   input  logic [5:0] ai_move,
   output logic       bu_en,
   output logic [3:0] bu_pid,
   output logic [5:0] bu_move,
   input  logic       bu_done,
   output logic       player,
   output logic       busy,
   output logic       ai_timeout,
   output logic [7:0] move_count
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      HUMAN_WAIT = 3'd1,
      AI_START   = 3'd2,
      AI_WAIT    = 3'd3,
      ISSUE      = 3'd4,
      BU_WAIT    = 3'd5,
      TURN_END   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [3:0]  bu_pid_q, bu_pid_d;
   logic [5:0]  bu_move_q, bu_move_d;
   logic        player_q, player_d;
   logic        ai_timeout_q, ai_timeout_d;
   logic [7:0]  move_count_q, move_count_d;
   logic        hum_ack_q, hum_ack_d;
   logic        hum_rej_q, hum_rej_d;
   logic        bu_en_q, bu_en_d;
   logic        hum_req_q;
   logic        ai_turn;

   assign ai_turn = (AI_ENABLE != 0) && (player_q == AI_PLAYER) && !ai_timeout_q;

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         bu_pid_q     <= '0;
         bu_move_q    <= '0;
         player_q     <= 1'b0;
         ai_timeout_q <= 1'b0;
         move_count_q <= '0;
         hum_ack_q    <= 1'b0;
         hum_rej_q    <= 1'b0;
         bu_en_q      <= 1'b0;
         hum_req_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         bu_pid_q     <= bu_pid_d;
         bu_move_q    <= bu_move_d;
         player_q     <= player_d;
         ai_timeout_q <= ai_timeout_d;
         move_count_q <= move_count_d;
         hum_ack_q    <= hum_ack_d;
         hum_rej_q    <= hum_rej_d;
         bu_en_q      <= bu_en_d;
         hum_req_q    <= hum_req;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bu_pid_d     = bu_pid_q;
      bu_move_d    = bu_move_q;
      player_d     = player_q;
      ai_timeout_d = ai_timeout_q;
      move_count_d = move_count_q;
      hum_ack_d    = 1'b0;
      bu_en_d      = 1'b0;
      // A request made while the engine owns the turn is refused once per new request.
      hum_rej_d    = hum_req && !hum_req_q && ai_turn && (state_q != HUMAN_WAIT);

      case (state_q)
         IDLE: begin
            state_d = ai_turn ? AI_START : HUMAN_WAIT;
         end
         HUMAN_WAIT: begin
            if (hum_req) begin
               bu_pid_d  = hum_pid;
               bu_move_d = hum_move;
               hum_ack_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         AI_START: begin
            timer_d = '0;
            state_d = AI_WAIT;
         end
         AI_WAIT: begin
            timer_d = timer_q + 24'd1;
            if (ai_done) begin
               bu_pid_d  = ai_pid;
               bu_move_d = ai_move;
               state_d   = ISSUE;
            end else if (timer_q == AI_TIMEOUT - 24'd1) begin
               // Engine gave up: the human takes over this side for the rest of the game.
               ai_timeout_d = 1'b1;
               state_d      = HUMAN_WAIT;
            end
         end
         ISSUE: begin
            bu_en_d = 1'b1;
            state_d = BU_WAIT;
         end
         BU_WAIT: begin
            if (bu_done) begin
               state_d = TURN_END;
            end
         end
         TURN_END: begin
            player_d = ~player_q;
            if (move_count_q != 8'hFF) begin
               move_count_d = move_count_q + 8'd1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign hum_ack    = hum_ack_q;
   assign hum_rej    = hum_rej_q;
   assign ai_start   = (state_q == AI_START);
   assign bu_en      = bu_en_q;
   assign bu_pid     = bu_pid_q;
   assign bu_move    = bu_move_q;
   assign player     = player_q;
   assign busy       = (state_q != IDLE) && (state_q != HUMAN_WAIT);
   assign ai_timeout = ai_timeout_q;
   assign move_count = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | tb_turn_scheduler: directed checks of turn_scheduler in human-only and AI modes.   |
// | Revision: 1.0 initial                                                              |
// +----------------------------------------------------------------------------------+
module tb_turn_scheduler;

   logic clk = 1'b0;
   logic RST = 1'b1;
   always #5 clk = ~clk;

   // Instance A: both sides human
   logic       a_hum_req = 0, a_ai_done = 0, a_bu_done = 0;
   logic [3:0] a_hum_pid = 0, a_ai_pid = 0;
   logic [5:0] a_hum_move = 0, a_ai_move = 0;
   logic       a_hum_ack, a_hum_rej, a_ai_start, a_bu_en, a_player, a_busy, a_ai_timeout;
   logic [3:0] a_bu_pid;
   logic [5:0] a_bu_move;
   logic [7:0] a_move_count;

   // Instance B: black played by the engine, short timeout
   logic       b_hum_req = 0, b_ai_done = 0, b_bu_done = 0;
   logic [3:0] b_hum_pid = 0, b_ai_pid = 0;
   logic [5:0] b_hum_move = 0, b_ai_move = 0;
   logic       b_hum_ack, b_hum_rej, b_ai_start, b_bu_en, b_player, b_busy, b_ai_timeout;
   logic [3:0] b_bu_pid;
   logic [5:0] b_bu_move;
   logic [7:0] b_move_count;

   turn_scheduler #(.AI_ENABLE(0), .AI_PLAYER(1'b1), .AI_TIMEOUT(24'd16)) dut_a (
      .clk(clk), .RST(RST),
      .hum_req(a_hum_req), .hum_pid(a_hum_pid), .hum_move(a_hum_move),
      .hum_ack(a_hum_ack), .hum_rej(a_hum_rej), .ai_start(a_ai_start),
      .ai_done(a_ai_done), .ai_pid(a_ai_pid), .ai_move(a_ai_move),
      .bu_en(a_bu_en), .bu_pid(a_bu_pid), .bu_move(a_bu_move), .bu_done(a_bu_done),
      .player(a_player), .busy(a_busy), .ai_timeout(a_ai_timeout), .move_count(a_move_count)
   );

   turn_scheduler #(.AI_ENABLE(1), .AI_PLAYER(1'b1), .AI_TIMEOUT(24'd16)) dut_b (
      .clk(clk), .RST(RST),
      .hum_req(b_hum_req), .hum_pid(b_hum_pid), .hum_move(b_hum_move),
      .hum_ack(b_hum_ack), .hum_rej(b_hum_rej), .ai_start(b_ai_start),
      .ai_done(b_ai_done), .ai_pid(b_ai_pid), .ai_move(b_ai_move),
      .bu_en(b_bu_en), .bu_pid(b_bu_pid), .bu_move(b_bu_move), .bu_done(b_bu_done),
      .player(b_player), .busy(b_busy), .ai_timeout(b_ai_timeout), .move_count(b_move_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Pulse counters, sampled mid-cycle
   int na_bu_en = 0, na_ack = 0, na_rej = 0, na_start = 0;
   int nb_bu_en = 0, nb_ack = 0, nb_rej = 0, nb_start = 0;
   always @(negedge clk) begin
      if (a_bu_en)    na_bu_en++;
      if (a_hum_ack)  na_ack++;
      if (a_hum_rej)  na_rej++;
      if (a_ai_start) na_start++;
      if (b_bu_en)    nb_bu_en++;
      if (b_hum_ack)  nb_ack++;
      if (b_hum_rej)  nb_rej++;
      if (b_ai_start) nb_start++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic a_turn(input logic [3:0] pid, input logic [5:0] mv);
      a_hum_pid  = pid;
      a_hum_move = mv;
      a_hum_req  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (a_hum_ack) break;
      end
      chk("a_ack_wait", {31'd0, a_hum_ack}, 32'd1);
      a_hum_req = 1'b0;
      tick();
      chk("a_bu_en", {31'd0, a_bu_en}, 32'd1);
      a_bu_done = 1'b1;
      tick();
      a_bu_done = 1'b0;
      tick();
   endtask

   task automatic b_turn(input logic [3:0] pid, input logic [5:0] mv);
      b_hum_pid  = pid;
      b_hum_move = mv;
      b_hum_req  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (b_hum_ack) break;
      end
      chk("b_ack_wait", {31'd0, b_hum_ack}, 32'd1);
      b_hum_req = 1'b0;
      tick();
      chk("b_bu_en", {31'd0, b_bu_en}, 32'd1);
      chk("b_bu_pid", {28'd0, b_bu_pid}, {28'd0, pid});
      chk("b_bu_move", {26'd0, b_bu_move}, {26'd0, mv});
      b_bu_done = 1'b1;
      tick();
      b_bu_done = 1'b0;
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_player", {31'd0, a_player}, 32'd0);
      chk("rst_count", {24'd0, a_move_count}, 32'd0);
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_ack", {31'd0, a_hum_ack}, 32'd0);
      chk("rst_bu_en", {31'd0, a_bu_en}, 32'd0);
      chk("rst_bu_pid", {28'd0, a_bu_pid}, 32'd0);
      chk("rst_ai_start", {31'd0, b_ai_start}, 32'd0);
      chk("rst_ai_timeout", {31'd0, b_ai_timeout}, 32'd0);
      RST = 1'b0;
      tick();

      // Human move with AI disabled: ack at N+1, bu_en at N+2
      a_hum_pid = 4'h3; a_hum_move = 6'o23; a_hum_req = 1'b1;
      tick();
      chk("t1_ack", {31'd0, a_hum_ack}, 32'd1);
      chk("t1_no_early_bu_en", {31'd0, a_bu_en}, 32'd0);
      chk("t1_busy", {31'd0, a_busy}, 32'd1);
      a_hum_req = 1'b0;
      tick();
      chk("t1_bu_en", {31'd0, a_bu_en}, 32'd1);
      chk("t1_ack_pulse", {31'd0, a_hum_ack}, 32'd0);
      chk("t1_bu_pid", {28'd0, a_bu_pid}, 32'h3);
      chk("t1_bu_move", {26'd0, a_bu_move}, 32'o23);
      tick();
      chk("t1_bu_en_pulse", {31'd0, a_bu_en}, 32'd0);
      a_bu_done = 1'b1;
      tick();
      a_bu_done = 1'b0;
      tick();
      chk("t1_player", {31'd0, a_player}, 32'd1);
      chk("t1_count", {24'd0, a_move_count}, 32'd1);
      chk("t1_no_rej", na_rej, 0);

      // Stray done pulses while waiting for a human move
      tick();
      a_bu_done = 1'b1; a_ai_done = 1'b1; a_ai_pid = 4'h9;
      tick();
      a_bu_done = 1'b0; a_ai_done = 1'b0;
      repeat (2) tick();
      chk("t6_player", {31'd0, a_player}, 32'd1);
      chk("t6_count", {24'd0, a_move_count}, 32'd1);
      chk("t6_busy", {31'd0, a_busy}, 32'd0);
      chk("t6_bu_pid_hold", {28'd0, a_bu_pid}, 32'h3);
      chk("t6_bu_en_count", na_bu_en, 1);

      // Reset right after hum_ack abandons the turn
      a_hum_pid = 4'h5; a_hum_move = 6'o07; a_hum_req = 1'b1;
      tick();
      chk("t5_ack", {31'd0, a_hum_ack}, 32'd1);
      RST = 1'b1; a_hum_req = 1'b0;
      tick();
      chk("t5_bu_en", {31'd0, a_bu_en}, 32'd0);
      chk("t5_player", {31'd0, a_player}, 32'd0);
      chk("t5_count", {24'd0, a_move_count}, 32'd0);
      chk("t5_busy", {31'd0, a_busy}, 32'd0);
      RST = 1'b0;
      repeat (3) tick();
      chk("t5_no_bu_en", na_bu_en, 1);

      // Counter saturation
      for (int t = 0; t < 255; t++) a_turn(4'(t), 6'(t));
      chk("t6_count_255", {24'd0, a_move_count}, 32'd255);
      a_turn(4'h1, 6'o01);
      chk("t6_count_sat", {24'd0, a_move_count}, 32'd255);
      chk("t6_player_256", {31'd0, a_player}, 32'd0);
      chk("t6_no_ai_start", na_start, 0);

      // AI mode: white human move, then one ai_start
      b_turn(4'h2, 6'o12);
      chk("t2_player", {31'd0, b_player}, 32'd1);
      tick();
      chk("t2_ai_start", {31'd0, b_ai_start}, 32'd1);
      chk("t2_busy", {31'd0, b_busy}, 32'd1);
      tick();
      chk("t2_ai_start_pulse", {31'd0, b_ai_start}, 32'd0);
      // Human request during the engine's turn is refused once
      b_hum_req = 1'b1;
      tick();
      chk("t3_rej", {31'd0, b_hum_rej}, 32'd1);
      chk("t3_no_ack", {31'd0, b_hum_ack}, 32'd0);
      tick();
      chk("t3_rej_pulse", {31'd0, b_hum_rej}, 32'd0);
      b_hum_req = 1'b0;
      repeat (7) tick();
      b_ai_done = 1'b1; b_ai_pid = 4'h8; b_ai_move = 6'o54;
      tick();
      b_ai_done = 1'b0; b_ai_pid = 4'h0; b_ai_move = 6'o00;
      chk("t2_no_early_bu_en", {31'd0, b_bu_en}, 32'd0);
      tick();
      chk("t2_bu_en", {31'd0, b_bu_en}, 32'd1);
      chk("t2_bu_pid", {28'd0, b_bu_pid}, 32'h8);
      chk("t2_bu_move", {26'd0, b_bu_move}, 32'o54);
      b_bu_done = 1'b1;
      tick();
      b_bu_done = 1'b0;
      tick();
      chk("t2_player_back", {31'd0, b_player}, 32'd0);
      chk("t2_count", {24'd0, b_move_count}, 32'd2);
      chk("t2_bu_en_count", nb_bu_en, 2);
      chk("t2_start_count", nb_start, 1);
      chk("t3_rej_count", nb_rej, 1);
      chk("t3_ack_count", nb_ack, 1);

      // Engine timeout
      b_turn(4'h6, 6'o34);
      tick();
      chk("t4_ai_start", {31'd0, b_ai_start}, 32'd1);
      repeat (16) tick();
      chk("t4_not_yet", {31'd0, b_ai_timeout}, 32'd0);
      chk("t4_busy", {31'd0, b_busy}, 32'd1);
      tick();
      chk("t4_timeout", {31'd0, b_ai_timeout}, 32'd1);
      chk("t4_human_wait", {31'd0, b_busy}, 32'd0);
      b_turn(4'hA, 6'o11);
      chk("t4_player", {31'd0, b_player}, 32'd0);
      chk("t4_count", {24'd0, b_move_count}, 32'd4);
      b_turn(4'h4, 6'o22);
      repeat (3) tick();
      chk("t4_no_more_start", nb_start, 2);
      chk("t4_sticky", {31'd0, b_ai_timeout}, 32'd1);
      chk("t4_busy_human", {31'd0, b_busy}, 32'd0);
      chk("t4_no_rej", nb_rej, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
